// File: rtl/expr_eval.sv
// expr_eval
//   Streaming ASCII arithmetic-expression recogniser and evaluator.
//   One character is consumed per cycle when in_valid is high. Numbers are
//   multi-digit unsigned decimals; '+', optional '-', and '*' are applied
//   with normal precedence. '=' terminates the expression and pulses done.
//
// Parameters
//   WIDTH       result / accumulator width in bits
//   MAX_DIGITS  maximum digits per operand (leading zeros included)
//   ENABLE_SUB  1: '-' is an add-op, 0: '-' is an illegal character
//
// Ports
//   clk       clock, rising edge
//   clr       asynchronous active-low reset
//   in_valid  qualifies in
//   in        ASCII character
//   out       accepted prefix is a complete valid expression
//   err       sticky syntax error for the current expression
//   done      one-cycle pulse after '=' is accepted
//   result    value of the last successful expression
//   ovf       overflow/underflow flag belonging to result
module expr_eval #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4,
  parameter int ENABLE_SUB = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic             out,
  output logic             err,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_NINE  = 8'h39;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NUM  = 2'd1,
    S_OP   = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] num_reg, num_next;
  logic [WIDTH-1:0] term_reg, term_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pend_mul_reg, pend_mul_next;
  logic             pend_sub_reg, pend_sub_next;
  logic             ovf_acc_reg, ovf_acc_next;
  logic             ovf_reg, ovf_next;
  logic             err_reg, err_next;
  logic             done_reg, done_next;
  logic             out_reg, out_next;

  // ---------------------------------------------------------------------
  // Character classification
  // ---------------------------------------------------------------------
  logic       is_digit, is_plus, is_minus, is_mul, is_eq, is_addop;
  logic [3:0] digit_val;

  assign is_digit  = (in >= CH_ZERO) && (in <= CH_NINE);
  assign digit_val = in[3:0];
  assign is_plus   = (in == CH_PLUS);
  // With subtraction disabled '-' falls through to the illegal class.
  assign is_minus  = (ENABLE_SUB != 0) && (in == CH_MINUS);
  assign is_mul    = (in == CH_MUL);
  assign is_eq     = (in == CH_EQ);
  assign is_addop  = is_plus || is_minus;

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  // Digit step num*10+d computed 4 bits wider so anything above WIDTH bits
  // flags an overflow. num is always 0 outside NUM, so the same path
  // serves the first digit of an operand.
  logic [WIDTH+3:0] digit_full;
  logic             digit_ovf;

  assign digit_full = ({4'b0000, num_reg} * (WIDTH+4)'(10)) + (WIDTH+4)'(digit_val);
  assign digit_ovf  = |digit_full[WIDTH+3:WIDTH];

  // Single shared multiplier: both '*' and the additive fold need term*num.
  logic [2*WIDTH-1:0] prod_full;
  logic               prod_ovf;

  assign prod_full = {{WIDTH{1'b0}}, term_reg} * {{WIDTH{1'b0}}, num_reg};
  assign prod_ovf  = |prod_full[2*WIDTH-1:WIDTH];

  // Value of the term that just closed, and whether forming it overflowed.
  logic [WIDTH-1:0] fold_t;
  logic             fold_t_ovf;

  assign fold_t     = pend_mul_reg ? prod_full[WIDTH-1:0] : num_reg;
  assign fold_t_ovf = pend_mul_reg && prod_ovf;

  // Add or subtract the closed term into the running sum; the extra top
  // bit is the carry out (add) or the borrow (subtract).
  logic [WIDTH:0]   sum_add, sum_sub;
  logic [WIDTH-1:0] fold_sum;
  logic             fold_sum_ovf;
  logic             fold_ovf;

  assign sum_add      = {1'b0, sum_reg} + {1'b0, fold_t};
  assign sum_sub      = {1'b0, sum_reg} - {1'b0, fold_t};
  assign fold_sum     = pend_sub_reg ? sum_sub[WIDTH-1:0] : sum_add[WIDTH-1:0];
  assign fold_sum_ovf = pend_sub_reg ? sum_sub[WIDTH] : sum_add[WIDTH];
  assign fold_ovf     = fold_t_ovf || fold_sum_ovf;

  // ---------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    num_next      = num_reg;
    term_next     = term_reg;
    sum_next      = sum_reg;
    cnt_next      = cnt_reg;
    pend_mul_next = pend_mul_reg;
    pend_sub_next = pend_sub_reg;
    ovf_acc_next  = ovf_acc_reg;
    result_next   = result_reg;
    ovf_next      = ovf_reg;
    done_next     = 1'b0;
    // err is sticky for an expression but drops once its done has been shown.
    err_next      = done_reg ? 1'b0 : err_reg;

    if (in_valid) begin
      if (is_eq) begin
        // Every '=' ends the expression: pulse done and start afresh.
        done_next     = 1'b1;
        state_next    = S_IDLE;
        num_next      = '0;
        term_next     = '0;
        sum_next      = '0;
        cnt_next      = '0;
        pend_mul_next = 1'b0;
        pend_sub_next = 1'b0;
        ovf_acc_next  = 1'b0;
        if (state_reg == S_NUM) begin
          result_next = fold_sum;
          ovf_next    = ovf_acc_reg || fold_ovf;
          err_next    = 1'b0;
        end else begin
          // Failed termination: report it through err in the done cycle,
          // leave the previous result untouched.
          err_next    = 1'b1;
        end
      end else begin
        unique case (state_reg)
          S_IDLE, S_OP: begin
            if (is_digit) begin
              state_next   = S_NUM;
              num_next     = digit_full[WIDTH-1:0];
              cnt_next     = CNT_W'(1);
              ovf_acc_next = ovf_acc_reg || digit_ovf;
            end else begin
              // Operator with no left operand, or an illegal character.
              state_next = S_ERR;
              err_next   = 1'b1;
            end
          end

          S_NUM: begin
            if (is_digit) begin
              if (cnt_reg == CNT_W'(MAX_DIGITS)) begin
                state_next = S_ERR;
                err_next   = 1'b1;
              end else begin
                num_next     = digit_full[WIDTH-1:0];
                cnt_next     = cnt_reg + CNT_W'(1);
                ovf_acc_next = ovf_acc_reg || digit_ovf;
              end
            end else if (is_mul) begin
              state_next    = S_OP;
              term_next     = fold_t;
              ovf_acc_next  = ovf_acc_reg || fold_t_ovf;
              pend_mul_next = 1'b1;
              num_next      = '0;
              cnt_next      = '0;
            end else if (is_addop) begin
              state_next    = S_OP;
              sum_next      = fold_sum;
              ovf_acc_next  = ovf_acc_reg || fold_ovf;
              pend_sub_next = is_minus;
              pend_mul_next = 1'b0;
              num_next      = '0;
              cnt_next      = '0;
            end else begin
              state_next = S_ERR;
              err_next   = 1'b1;
            end
          end

          S_ERR: begin
            // Wait for '=' to resynchronise; everything else is dropped.
          end

          default: begin
            state_next = S_IDLE;
          end
        endcase
      end
    end

    out_next = (state_next == S_NUM);
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg    <= S_IDLE;
      num_reg      <= '0;
      term_reg     <= '0;
      sum_reg      <= '0;
      cnt_reg      <= '0;
      pend_mul_reg <= 1'b0;
      pend_sub_reg <= 1'b0;
      ovf_acc_reg  <= 1'b0;
      result_reg   <= '0;
      ovf_reg      <= 1'b0;
      err_reg      <= 1'b0;
      done_reg     <= 1'b0;
      out_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      num_reg      <= num_next;
      term_reg     <= term_next;
      sum_reg      <= sum_next;
      cnt_reg      <= cnt_next;
      pend_mul_reg <= pend_mul_next;
      pend_sub_reg <= pend_sub_next;
      ovf_acc_reg  <= ovf_acc_next;
      result_reg   <= result_next;
      ovf_reg      <= ovf_next;
      err_reg      <= err_next;
      done_reg     <= done_next;
      out_reg      <= out_next;
    end
  end

  assign out    = out_reg;
  assign err    = err_reg;
  assign done   = done_reg;
  assign result = result_reg;
  assign ovf    = ovf_reg;

endmodule

// File: tb/tb_expr_eval.sv
// tb_expr_eval
//   Drives one character stream into three expr_eval instances:
//     u0: WIDTH=16, subtraction enabled
//     u1: WIDTH=8,  subtraction enabled
//     u2: WIDTH=16, subtraction disabled
//   The reference model keeps the text of the current expression as a
//   string, decides well-formedness by scanning it, and evaluates it with
//   plain integer arithmetic. Expected per-cycle outputs are queued by the
//   driver and consumed by an independent monitor.
module tb_expr_eval;

  logic        clk      = 1'b0;
  logic        clr      = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_ch    = 8'h00;

  logic [2:0]  out_w, err_w, done_w, ovf_w;
  logic [15:0] res0, res2;
  logic [7:0]  res1;

  always #5 clk = ~clk;

  expr_eval #(.WIDTH(16), .MAX_DIGITS(4), .ENABLE_SUB(1)) u0 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_ch),
    .out(out_w[0]), .err(err_w[0]), .done(done_w[0]), .result(res0), .ovf(ovf_w[0])
  );

  expr_eval #(.WIDTH(8), .MAX_DIGITS(4), .ENABLE_SUB(1)) u1 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_ch),
    .out(out_w[1]), .err(err_w[1]), .done(done_w[1]), .result(res1), .ovf(ovf_w[1])
  );

  expr_eval #(.WIDTH(16), .MAX_DIGITS(4), .ENABLE_SUB(0)) u2 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_ch),
    .out(out_w[2]), .err(err_w[2]), .done(done_w[2]), .result(res2), .ovf(ovf_w[2])
  );

  typedef struct packed {
    logic        out;
    logic        err;
    logic        done;
    logic        ovf;
    logic [15:0] result;
  } exp_t;
  typedef exp_t [2:0] cyc_t;

  cyc_t   sbq[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_txn    = 0;

  // Reference model state
  string  expr_s = "";
  bit     m_err  [0:2];
  bit     m_done [0:2];
  bit     m_out  [0:2];
  bit     m_ovf  [0:2];
  longint m_res  [0:2];

  function automatic logic [15:0] res_of(input int c);
    case (c)
      0:       return res0;
      1:       return {8'h00, res1};
      default: return res2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // 0 = well-formed but incomplete (empty or ends in operator),
  // 1 = complete expression, 2 = syntax error somewhere in the prefix.
  function automatic int status(input string s, input bit sub_en);
    int  last = 0;   // 0 start, 1 digit, 2 operator
    int  cnt  = 0;
    byte c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c >= "0" && c <= "9") begin
        cnt  = (last == 1) ? cnt + 1 : 1;
        last = 1;
        if (cnt > 4) return 2;
      end else if (c == "+" || c == "*" || (c == "-" && sub_en)) begin
        if (last != 1) return 2;
        last = 2;
      end else begin
        return 2;
      end
    end
    return (last == 1) ? 1 : 0;
  endfunction

  // Evaluate a complete expression modulo 2^w, flagging any intermediate
  // number, product, sum or difference that leaves the range [0, 2^w).
  task automatic evaluate(input string s, input int w, output longint val, output bit ov);
    longint m     = longint'(1) << w;
    longint sum   = 0;
    longint term  = 0;
    longint f     = 0;
    longint p;
    bit     inprod = 0;
    bit     subnx  = 0;
    byte    c;
    ov = 0;
    for (int i = 0; i <= s.len(); i++) begin
      c = (i < s.len()) ? s[i] : "=";
      if (c >= "0" && c <= "9") begin
        f = f * 10 + longint'(c - "0");
      end else begin
        if (f >= m) ov = 1;
        f = f % m;
        if (inprod) begin
          p = term * f;
          if (p >= m) ov = 1;
          term = p % m;
        end else begin
          term = f;
        end
        f = 0;
        if (c == "*") begin
          inprod = 1;
        end else begin
          if (subnx) begin
            if (term > sum) ov = 1;
            sum = (sum - term + m) % m;
          end else begin
            sum = sum + term;
            if (sum >= m) begin
              ov  = 1;
              sum = sum - m;
            end
          end
          subnx  = (c == "-");
          inprod = 0;
        end
      end
    end
    val = sum;
  endtask

  task automatic reset_model();
    expr_s = "";
    for (int c = 0; c < 3; c++) begin
      m_err[c] = 0; m_done[c] = 0; m_out[c] = 0; m_ovf[c] = 0; m_res[c] = 0;
    end
  endtask

  // Present one cycle of input and queue what every instance must show after it.
  task automatic drive(input bit v, input byte ch);
    cyc_t   rec;
    string  nexpr;
    int     st;
    bit     sub_en;
    int     w;
    longint val;
    bit     ov;
    @(negedge clk);
    in_valid = v;
    in_ch    = ch;
    nexpr    = expr_s;
    if (v && ch != "=") nexpr = $sformatf("%s%c", expr_s, ch);
    for (int c = 0; c < 3; c++) begin
      sub_en = (c != 2);
      w      = (c == 1) ? 8 : 16;
      if (!v) begin
        m_err[c]  = m_err[c] && !m_done[c];
        m_done[c] = 0;
      end else if (ch == "=") begin
        st        = status(expr_s, sub_en);
        m_done[c] = 1;
        m_out[c]  = 0;
        if (st == 1) begin
          evaluate(expr_s, w, val, ov);
          m_res[c] = val;
          m_ovf[c] = ov;
          m_err[c] = 0;
        end else begin
          m_err[c] = 1;
        end
      end else begin
        st        = status(nexpr, sub_en);
        m_out[c]  = (st == 1);
        m_err[c]  = (st == 2);
        m_done[c] = 0;
      end
      rec[c].out    = m_out[c];
      rec[c].err    = m_err[c];
      rec[c].done   = m_done[c];
      rec[c].ovf    = m_ovf[c];
      rec[c].result = 16'(m_res[c]);
    end
    if (v && ch == "=") nexpr = "";
    expr_s = nexpr;
    sbq.push_back(rec);
  endtask

  task automatic run_str(input string s, input int gap_pct);
    for (int i = 0; i < s.len(); i++) begin
      for (int g = 0; g < 2; g++)
        if ($urandom_range(0, 99) < gap_pct) drive(1'b0, byte'($urandom_range(32, 126)));
      drive(1'b1, s[i]);
    end
    drive(1'b0, 8'h20);
  endtask

  task automatic expect_res(input int c, input int val, input bit ov);
    chk($sformatf("u%0d.result_literal", c), 64'(res_of(c)), 64'(val));
    chk($sformatf("u%0d.ovf_literal", c), 64'(ovf_w[c]), 64'(ov));
  endtask

  task automatic expect_flags(input int c, input bit e, input bit o);
    chk($sformatf("u%0d.err_literal", c), 64'(err_w[c]), 64'(e));
    chk($sformatf("u%0d.out_literal", c), 64'(out_w[c]), 64'(o));
  endtask

  task automatic check_all_zero(input string tag);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("%s.u%0d.out", tag, c), 64'(out_w[c]), 64'd0);
      chk($sformatf("%s.u%0d.err", tag, c), 64'(err_w[c]), 64'd0);
      chk($sformatf("%s.u%0d.done", tag, c), 64'(done_w[c]), 64'd0);
      chk($sformatf("%s.u%0d.ovf", tag, c), 64'(ovf_w[c]), 64'd0);
      chk($sformatf("%s.u%0d.result", tag, c), 64'(res_of(c)), 64'd0);
    end
  endtask

  function automatic string rand_expr();
    string s    = "";
    string pool = "0123456789+-*x =";
    string ops  = "+-*";
    int    r;
    int    n;
    int    nd;
    r = $urandom_range(0, 99);
    if (r < 12) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        s = $sformatf("%s%c", s, pool[$urandom_range(0, pool.len() - 1)]);
    end else begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        nd = ($urandom_range(0, 19) == 0) ? 5 : $urandom_range(1, 4);
        for (int d = 0; d < nd; d++) s = $sformatf("%s%0d", s, $urandom_range(0, 9));
        if (k < n - 1) s = $sformatf("%s%c", s, ops[$urandom_range(0, 2)]);
      end
    end
    if ($urandom_range(0, 19) != 0) s = $sformatf("%s=", s);
    return s;
  endfunction

  // Monitor: one queued expectation per driven cycle, compared 2 time
  // units after the edge that consumed it.
  initial begin
    cyc_t rec;
    forever begin
      @(posedge clk);
      #2;
      if (sbq.size() > 0) begin
        rec = sbq.pop_front();
        for (int c = 0; c < 3; c++) begin
          chk($sformatf("u%0d.out", c), 64'(out_w[c]), 64'(rec[c].out));
          chk($sformatf("u%0d.err", c), 64'(err_w[c]), 64'(rec[c].err));
          chk($sformatf("u%0d.done", c), 64'(done_w[c]), 64'(rec[c].done));
          chk($sformatf("u%0d.ovf", c), 64'(ovf_w[c]), 64'(rec[c].ovf));
          chk($sformatf("u%0d.result", c), 64'(res_of(c)), 64'(rec[c].result));
        end
        if (rec[0].done) begin
          n_txn++;
          $display("txn %0d: u0 result=%0d ovf=%0b err=%0b | u1 result=%0d ovf=%0b err=%0b | u2 result=%0d ovf=%0b err=%0b",
                   n_txn, res0, ovf_w[0], err_w[0], res1, ovf_w[1], err_w[1], res2, ovf_w[2], err_w[2]);
        end
      end
    end
  end

  initial begin
    reset_model();
    #1 clr = 1'b0;
    #2 check_all_zero("reset");
    #9 clr = 1'b1;

    run_str("1+2*3=", 0);
    expect_res(0, 7, 0);
    expect_flags(0, 0, 0);

    run_str("12*34-5=", 0);
    expect_res(0, 403, 0);
    run_str("2*3*4+1=", 0);
    expect_res(0, 25, 0);

    run_str("1++", 0);
    expect_flags(0, 1, 0);
    run_str("4=", 0);
    expect_res(0, 25, 0);
    run_str("4=", 0);
    expect_res(0, 4, 0);
    expect_flags(0, 0, 0);

    run_str("20*13=", 0);
    expect_res(1, 4, 1);
    expect_res(0, 260, 0);

    run_str("1-2=", 0);
    expect_res(1, 255, 1);
    expect_res(0, 65535, 1);
    expect_res(2, 260, 0);

    run_str("1234", 0);
    expect_flags(0, 0, 1);
    run_str("5", 0);
    expect_flags(0, 1, 0);
    run_str("=", 0);

    // Asynchronous clear in the middle of an expression.
    run_str("1+2", 0);
    @(posedge clk);
    #4 clr = 1'b0;
    #1 check_all_zero("clr");
    #6 clr = 1'b1;
    reset_model();
    run_str("3=", 0);
    expect_res(0, 3, 0);

    run_str("1+2*3=", 40);
    expect_res(0, 7, 0);

    run_str("5-1", 0);
    expect_flags(2, 1, 0);
    expect_flags(0, 0, 1);
    run_str("=", 0);
    expect_res(0, 4, 0);

    run_str("==", 0);

    for (int k = 0; k < 150; k++) run_str(rand_expr(), 20);

    drive(1'b0, 8'h20);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
